lc3_run_ctrl: RTL
=================

Name: lc3_run_ctrl

Overview:
- Synthesisable run controller for the LC3 datapath.
- Gates the datapath clock enable, and can free-run, single-step or stop the datapath.
- Stops automatically on a halt instruction word, on a PC breakpoint, or on a cycle-budget timeout. Reports why it stopped and how many cycles it ran.
- Sits between the top level (or bench) and the datapath. Replaces open-loop clock toggling until the IR equals 16'hFFFF.

Parameters:
- WORD_W, 16, width of IR and PC.
- HALT_WORD, 16'hFFFF, IR value that ends execution.
- CYC_W, 32, cycle counter width.
- MAX_CYCLES, 0, cycle budget; 0 disables the timeout.
- NUM_BP, 2, number of PC breakpoint comparators (1..8).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begin or resume free-run
- step  in  1  pulse; execute exactly one instruction
- stop  in  1  pulse; pause a running datapath
- ir_in  in  WORD_W  datapath IR
- pc_in  in  WORD_W  datapath PC
- instr_done  in  1  datapath pulse on the last cycle of an instruction
- bp_addr  in  NUM_BP*WORD_W  breakpoint addresses, slot i at bits [i*WORD_W +: WORD_W]
- bp_valid  in  NUM_BP  per-slot enable
- cpu_en  out  1  datapath clock enable
- running  out  1  state is RUN or STEP
- halted  out  1  HALT_WORD seen (sticky)
- timeout  out  1  cycle budget exhausted (sticky)
- bp_hit  out  1  stopped on breakpoint (held while PAUSED)
- bp_idx  out  clog2(NUM_BP) (min 1)  lowest-index matching slot
- cycle_count  out  CYC_W  enabled cycles since reset

Behaviour:
- Reset values: IDLE state; all outputs 0. Reset has priority over every input and aborts any operation.
- State machine, states IDLE, RUN, STEP, PAUSED, HALT, TOUT:
  - IDLE/PAUSED + start -> RUN.
  - IDLE/PAUSED + step -> STEP.
  - If start and step arrive together, start wins.
  - RUN + stop -> PAUSED.
  - STEP + instr_done -> PAUSED.
  - HALT and TOUT are terminal; only rst leaves them. start, step and stop are ignored there.
- cpu_en is combinational: 1 exactly when the state is RUN or STEP. The first enabled cycle is the cycle after the start/step edge. cpu_en drops in the cycle after a stop condition is sampled.
- Stop conditions are evaluated every edge while in RUN or STEP. Priority, highest first:
  1. ir_in == HALT_WORD -> HALT; halted is set.
  2. MAX_CYCLES != 0 and cycle_count == MAX_CYCLES-1 -> TOUT; timeout is set.
  3. instr_done and some bp_valid[i] with pc_in == bp_addr[i] -> PAUSED; bp_hit = 1 and bp_idx = lowest matching i.
  4. stop (RUN only), or instr_done (STEP only) -> PAUSED.
- The halt check needs no instr_done; it fires on the first enabled cycle in which the IR equals HALT_WORD.
- bp_hit is cleared on the transition out of PAUSED.
- Resume-over-breakpoint: after leaving PAUSED via a breakpoint, the breakpoint compare is masked until the first instr_done. Resuming therefore does not re-trigger on the same PC.
- cycle_count increments by 1 on every edge where cpu_en = 1, including the edge that transitions to a stop state. It wraps modulo 2^CYC_W and is never cleared except by rst.
- instr_done, stop and breakpoints are ignored while cpu_en = 0.

Optional Feature:
- Macro: LC3_RUNCTRL_TRACE_EN.
- Defined: adds outputs instr_count (CYC_W) and last_pc (WORD_W).
  - instr_count increments on each instr_done while cpu_en = 1.
  - last_pc captures pc_in on each such instr_done.
  - Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Halt: rst, then start; the model holds ir_in = 16'h1234 for 5 cycles, then 16'hFFFF.
  -> cpu_en high for exactly 6 cycles, then halted = 1 and running = 0.
  -> cycle_count = 6; a later start leaves cpu_en = 0.
- Single step: from IDLE, pulse step; instr_done arrives on the 3rd enabled cycle.
  -> state PAUSED, cpu_en = 0, cycle_count = 3.
  -> a second step gives another 3 enabled cycles, cycle_count = 6.
- Breakpoint: bp_addr slot1 = 16'h3005, bp_valid = 2'b10; run until instr_done with pc_in = 16'h3005.
  -> bp_hit = 1, bp_idx = 1, PAUSED.
  -> start resumes, and the next instr_done at 16'h3005 without an intervening instr_done does not re-hit.
- Timeout: MAX_CYCLES = 10, IR never equals HALT_WORD.
  -> timeout = 1 and cycle_count = 10; cpu_en is low from the 11th cycle.
  -> a simultaneous HALT_WORD on the 10th cycle sets halted instead, and timeout stays 0.
- Stop and reset mid-run: stop during RUN -> PAUSED next edge, count frozen.
  -> rst asserted while RUN -> all outputs 0 on the following edge, including cycle_count.
- Trace (macro defined): 4 instructions retire at PCs 16'h3000..16'h3003.
  -> instr_count = 4, last_pc = 16'h3003.

Source files
------------

// File: rtl/lc3_run_ctrl.sv
// lc3_run_ctrl: run/step/stop controller gating the LC3 datapath clock enable.
// Optional trace outputs (instr_count, last_pc) are built when LC3_RUNCTRL_TRACE_EN is defined.
module lc3_run_ctrl #(
  parameter int          WORD_W     = 16,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF,
  parameter int          CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 32'd0,
  parameter int          NUM_BP     = 2,
  localparam int         BP_IDX_W   = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     step,
  input  logic                     stop,
  input  logic [WORD_W-1:0]        ir_in,
  input  logic [WORD_W-1:0]        pc_in,
  input  logic                     instr_done,
  input  logic [NUM_BP*WORD_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_valid,
  output logic                     cpu_en,
  output logic                     running,
  output logic                     halted,
  output logic                     timeout,
  output logic                     bp_hit,
  output logic [BP_IDX_W-1:0]      bp_idx,
  output logic [CYC_W-1:0]         cycle_count
`ifdef LC3_RUNCTRL_TRACE_EN
  ,
  output logic [CYC_W-1:0]         instr_count,
  output logic [WORD_W-1:0]        last_pc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_PAUSED = 3'd3,
    S_HALT   = 3'd4,
    S_TOUT   = 3'd5
  } state_e;

  localparam logic [CYC_W-1:0] TOUT_AT = CYC_W'(MAX_CYCLES - 32'd1);

  state_e                state_q, state_d;
  logic                  halted_q, halted_d;
  logic                  timeout_q, timeout_d;
  logic                  bp_hit_q, bp_hit_d;
  logic [BP_IDX_W-1:0]   bp_idx_q, bp_idx_d;
  logic [CYC_W-1:0]      cycle_count_q, cycle_count_d;
  logic                  bp_mask_q, bp_mask_d;

  logic                  cpu_en_s;
  logic [NUM_BP-1:0]     bp_vec_s;
  logic                  bp_any_s;
  logic [BP_IDX_W-1:0]   bp_first_s;
  logic                  tout_s;

  assign cpu_en_s = (state_q == S_RUN) || (state_q == S_STEP);
  assign tout_s   = (MAX_CYCLES != 32'd0) && (cycle_count_q == TOUT_AT);

  // Descending scan so the lowest matching slot is the one left in bp_first_s.
  always_comb begin
    bp_vec_s   = '0;
    bp_first_s = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      bp_vec_s[i] = bp_valid[i] && (pc_in == bp_addr[i*WORD_W +: WORD_W]);
      bp_first_s  = bp_vec_s[i] ? BP_IDX_W'(i) : bp_first_s;
    end
    bp_any_s = |bp_vec_s;
  end

  always_comb begin
    state_d       = state_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;
    bp_hit_d      = bp_hit_q;
    bp_idx_d      = bp_idx_q;
    cycle_count_d = cycle_count_q;
    bp_mask_d     = bp_mask_q;
    case (state_q)
      S_IDLE, S_PAUSED: begin
        if (start || step) begin
          state_d   = start ? S_RUN : S_STEP;
          // Leaving a breakpoint pause: skip the compare until the current instruction retires.
          bp_mask_d = bp_mask_q | bp_hit_q;
          bp_hit_d  = 1'b0;
          bp_idx_d  = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN, S_STEP: begin
        cycle_count_d = cycle_count_q + CYC_W'(1);
        if (instr_done) begin
          bp_mask_d = 1'b0;
        end else begin
          bp_mask_d = bp_mask_q;
        end
        if (ir_in == HALT_WORD) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (tout_s) begin
          state_d   = S_TOUT;
          timeout_d = 1'b1;
        end else if (instr_done && !bp_mask_q && bp_any_s) begin
          state_d  = S_PAUSED;
          bp_hit_d = 1'b1;
          bp_idx_d = bp_first_s;
        end else if ((state_q == S_RUN) ? stop : instr_done) begin
          state_d = S_PAUSED;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
      bp_hit_q      <= 1'b0;
      bp_idx_q      <= '0;
      cycle_count_q <= '0;
      bp_mask_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      timeout_q     <= timeout_d;
      bp_hit_q      <= bp_hit_d;
      bp_idx_q      <= bp_idx_d;
      cycle_count_q <= cycle_count_d;
      bp_mask_q     <= bp_mask_d;
    end
  end

  assign cpu_en      = cpu_en_s;
  assign running     = cpu_en_s;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign bp_hit      = bp_hit_q;
  assign bp_idx      = bp_idx_q;
  assign cycle_count = cycle_count_q;

`ifdef LC3_RUNCTRL_TRACE_EN
  logic [CYC_W-1:0]  instr_count_q, instr_count_d;
  logic [WORD_W-1:0] last_pc_q, last_pc_d;

  always_comb begin
    instr_count_d = instr_count_q;
    last_pc_d     = last_pc_q;
    if (cpu_en_s && instr_done) begin
      instr_count_d = instr_count_q + CYC_W'(1);
      last_pc_d     = pc_in;
    end else begin
      instr_count_d = instr_count_q;
      last_pc_d     = last_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count_q <= '0;
      last_pc_q     <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      last_pc_q     <= last_pc_d;
    end
  end

  assign instr_count = instr_count_q;
  assign last_pc     = last_pc_q;
`endif

endmodule
